// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage driving a 16-bit asynchronous SRAM
// Each 32-bit access is split into a low and a high half-word phase; ready freezes upstream meanwhile.
module mem_stage #(
  parameter int          SRAM_WAIT = 2,
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_R_en,
  input  logic        mem_W_en,
  input  logic [31:0] alu_result,
  input  logic [31:0] val_rm,
  output logic        ready,
  output logic [31:0] mem_result,
  output logic [17:0] sram_addr,
  inout  wire  [15:0] sram_dq,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(SRAM_WAIT - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_is_write;
  logic [15:0] r_low_buf;
  logic [31:0] r_mem_result;

  logic        w_req;
  logic        w_last;
  logic        w_drive;
  logic [31:0] w_off;
  logic [15:0] w_wdata;
  logic        w_unused_bits;

  assign w_req   = mem_R_en | mem_W_en;
  assign w_last  = (r_cnt == LAST_CNT);
  assign w_off   = alu_result - BASE_ADDR;
  assign w_drive = r_is_write && ((r_state == S_LOW) || (r_state == S_HIGH));
  assign w_wdata = (r_state == S_HIGH) ? val_rm[31:16] : val_rm[15:0];
  // Byte-lane bits and address bits beyond the SRAM span are deliberately dropped.
  assign w_unused_bits = ^{w_off[31:19], w_off[1:0]};

  assign ready      = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
  assign mem_result = r_mem_result;
  assign sram_we_n  = ~w_drive;
  assign sram_dq    = w_drive ? w_wdata : 16'hzzzz;

  always_comb begin
    sram_addr = 18'd0;
    case (r_state)
      S_LOW:   sram_addr = {w_off[18:2], 1'b0};
      S_HIGH:  sram_addr = {w_off[18:2], 1'b1};
      default: sram_addr = 18'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_is_write   <= 1'b0;
      r_low_buf    <= 16'd0;
      r_mem_result <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= 4'd0;
          if (w_req) begin
            // A write wins when both enables are raised together.
            r_is_write <= mem_W_en;
            r_state    <= S_LOW;
          end
        end
        S_LOW: begin
          if (w_last) begin
            if (!r_is_write) r_low_buf <= sram_dq;
            r_cnt   <= 4'd0;
            r_state <= S_HIGH;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_HIGH: begin
          if (w_last) begin
            if (!r_is_write) r_mem_result <= {sram_dq, r_low_buf};
            r_cnt   <= 4'd0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_cnt   <= 4'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
// Two instances: SRAM_WAIT=2 for the main scenarios, SRAM_WAIT=1 for back-to-back timing.
module tb_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        r_en, w_en, r_en1, w_en1;
  logic [31:0] alu, val, alu1, val1;
  wire         ready, ready1, we_n, we_n1;
  wire  [31:0] mres, mres1;
  wire  [17:0] saddr, saddr1;
  wire  [15:0] dq, dq1;

  logic [15:0] rom   [0:31];
  logic [15:0] wmem  [0:31];
  logic [15:0] wmem1 [0:31];

  int checks = 0;
  int errors = 0;

  logic        exp_ready, exp_we;
  logic [17:0] exp_addr;
  logic [31:0] exp_res;
  logic [15:0] exp_dq;

  mem_stage #(.SRAM_WAIT(2), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .mem_R_en(r_en), .mem_W_en(w_en), .alu_result(alu), .val_rm(val),
    .ready(ready), .mem_result(mres), .sram_addr(saddr), .sram_dq(dq), .sram_we_n(we_n)
  );

  mem_stage #(.SRAM_WAIT(1), .BASE_ADDR(32'd1024)) dut1 (
    .clk(clk), .rst(rst), .mem_R_en(r_en1), .mem_W_en(w_en1), .alu_result(alu1), .val_rm(val1),
    .ready(ready1), .mem_result(mres1), .sram_addr(saddr1), .sram_dq(dq1), .sram_we_n(we_n1)
  );

  // SRAM models: drive read data whenever the DUT is not strobing a write, capture on writes.
  assign dq  = we_n  ? rom[saddr[4:0]]  : 16'hzzzz;
  assign dq1 = we_n1 ? rom[saddr1[4:0]] : 16'hzzzz;
  always @(posedge clk) if (!we_n)  wmem[saddr[4:0]]   <= dq;
  always @(posedge clk) if (!we_n1) wmem1[saddr1[4:0]] <= dq1;

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (saddr !== 18'd0) begin errors++; $display("FAIL reset_addr got %h want 0", saddr); end
    checks++; if (we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n got %b want 1", we_n); end
    checks++; if (mres !== 32'd0) begin errors++; $display("FAIL reset_mem_result got %h want 0", mres); end
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready1 got %b want 1", ready1); end
    rst = 1'b0;
  endtask

  task automatic test_idle;
    val = 32'h5A3C5A3C;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_ready c%0d got %b want 1", c, ready); end
      checks++; if (we_n !== 1'b1) begin errors++; $display("FAIL idle_we_n c%0d got %b want 1", c, we_n); end
      checks++; if (saddr !== 18'd0) begin errors++; $display("FAIL idle_addr c%0d got %h want 0", c, saddr); end
      checks++; if (dq !== 16'hA5C3) begin errors++; $display("FAIL idle_dq_released c%0d got %h want a5c3", c, dq); end
    end
  endtask

  task automatic test_read;
    @(negedge clk);
    alu = 32'd1032; val = 32'h41104110; r_en = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 2) w_en = 1'b1;  // late write request must not turn the read into a write
      #1;
      exp_ready = (c >= 5);
      exp_addr  = (c == 1 || c == 2) ? 18'd4 : (c == 3 || c == 4) ? 18'd5 : 18'd0;
      exp_res   = (c >= 5) ? 32'hDEADBEEF : 32'd0;
      checks++; if (ready !== exp_ready) begin errors++; $display("FAIL read_ready c%0d got %b want %b", c, ready, exp_ready); end
      checks++; if (saddr !== exp_addr) begin errors++; $display("FAIL read_addr c%0d got %h want %h", c, saddr, exp_addr); end
      checks++; if (we_n !== 1'b1) begin errors++; $display("FAIL read_we_n c%0d got %b want 1", c, we_n); end
      checks++; if (mres !== exp_res) begin errors++; $display("FAIL read_result c%0d got %h want %h", c, mres, exp_res); end
      if (c == 5) begin r_en = 1'b0; w_en = 1'b0; end
    end
  endtask

  task automatic test_write(input logic [31:0] a, input logic [31:0] d, input logic rd,
                            input int word, input logic [31:0] hold);
    @(negedge clk);
    alu = a; val = d; r_en = rd; w_en = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_ready = (c == 5);
      exp_we    = !(c >= 1 && c <= 4);
      exp_addr  = (c == 1 || c == 2) ? 18'(2 * word) : (c == 3 || c == 4) ? 18'(2 * word + 1) : 18'd0;
      exp_dq    = (c <= 2) ? d[15:0] : d[31:16];
      checks++; if (ready !== exp_ready) begin errors++; $display("FAIL write_ready c%0d got %b want %b", c, ready, exp_ready); end
      checks++; if (we_n !== exp_we) begin errors++; $display("FAIL write_we_n c%0d got %b want %b", c, we_n, exp_we); end
      checks++; if (saddr !== exp_addr) begin errors++; $display("FAIL write_addr c%0d got %h want %h", c, saddr, exp_addr); end
      checks++; if (mres !== hold) begin errors++; $display("FAIL write_result_held c%0d got %h want %h", c, mres, hold); end
      if (c >= 1 && c <= 4) begin
        checks++; if (dq !== exp_dq) begin errors++; $display("FAIL write_dq c%0d got %h want %h", c, dq, exp_dq); end
      end
      if (c == 5) begin r_en = 1'b0; w_en = 1'b0; end
    end
    checks++; if (wmem[2*word] !== d[15:0]) begin errors++; $display("FAIL write_mem_lo got %h want %h", wmem[2*word], d[15:0]); end
    checks++; if (wmem[2*word+1] !== d[31:16]) begin errors++; $display("FAIL write_mem_hi got %h want %h", wmem[2*word+1], d[31:16]); end
  endtask

  task automatic test_reset_mid_write;
    @(negedge clk);
    alu = 32'd1039; val = 32'hAAAA5555; w_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (saddr !== 18'd7) begin errors++; $display("FAIL rstw_pre_addr got %h want 7", saddr); end
    rst = 1'b1;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstw_ready got %b want 0", ready); end
    checks++; if (saddr !== 18'd0) begin errors++; $display("FAIL rstw_addr got %h want 0", saddr); end
    checks++; if (we_n !== 1'b1) begin errors++; $display("FAIL rstw_we_n got %b want 1", we_n); end
    checks++; if (mres !== 32'd0) begin errors++; $display("FAIL rstw_result got %h want 0", mres); end
    checks++; if (dq !== 16'hA5C3) begin errors++; $display("FAIL rstw_dq_released got %h want a5c3", dq); end
    checks++; if (wmem[6] !== 16'h5555) begin errors++; $display("FAIL rstw_partial_lo got %h want 5555", wmem[6]); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_ready = (c == 5);
      exp_addr  = (c == 1 || c == 2) ? 18'd6 : (c == 3 || c == 4) ? 18'd7 : 18'd0;
      checks++; if (ready !== exp_ready) begin errors++; $display("FAIL rstw_restart_ready c%0d got %b want %b", c, ready, exp_ready); end
      checks++; if (saddr !== exp_addr) begin errors++; $display("FAIL rstw_restart_addr c%0d got %h want %h", c, saddr, exp_addr); end
      if (c == 5) w_en = 1'b0;
    end
    checks++; if (wmem[6] !== 16'h5555) begin errors++; $display("FAIL rstw_mem_lo got %h want 5555", wmem[6]); end
    checks++; if (wmem[7] !== 16'hAAAA) begin errors++; $display("FAIL rstw_mem_hi got %h want aaaa", wmem[7]); end
    checks++; if (mres !== 32'd0) begin errors++; $display("FAIL rstw_result_after got %h want 0", mres); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    alu1 = 32'd1040; val1 = 32'hEEEEEEEE; r_en1 = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_ready = (c == 3 || c == 7 || c == 8);
      exp_we    = !(c == 5 || c == 6);
      exp_addr  = (c == 1) ? 18'd8 : (c == 2) ? 18'd9 : (c == 5) ? 18'd10 : (c == 6) ? 18'd11 : 18'd0;
      checks++; if (ready1 !== exp_ready) begin errors++; $display("FAIL b2b_ready c%0d got %b want %b", c, ready1, exp_ready); end
      checks++; if (we_n1 !== exp_we) begin errors++; $display("FAIL b2b_we_n c%0d got %b want %b", c, we_n1, exp_we); end
      checks++; if (saddr1 !== exp_addr) begin errors++; $display("FAIL b2b_addr c%0d got %h want %h", c, saddr1, exp_addr); end
      if (c >= 3) begin
        checks++; if (mres1 !== 32'h22221111) begin errors++; $display("FAIL b2b_result c%0d got %h want 22221111", c, mres1); end
      end
      if (c == 3) begin r_en1 = 1'b0; w_en1 = 1'b1; alu1 = 32'd1044; val1 = 32'h33334444; end
      if (c == 7) w_en1 = 1'b0;
    end
    checks++; if (wmem1[10] !== 16'h4444) begin errors++; $display("FAIL b2b_mem_lo got %h want 4444", wmem1[10]); end
    checks++; if (wmem1[11] !== 16'h3333) begin errors++; $display("FAIL b2b_mem_hi got %h want 3333", wmem1[11]); end
  endtask

  initial begin
    rst = 1'b1;
    r_en = 1'b0; w_en = 1'b0; alu = 32'd0; val = 32'd0;
    r_en1 = 1'b0; w_en1 = 1'b0; alu1 = 32'd0; val1 = 32'd0;
    for (int i = 0; i < 32; i++) rom[i] = 16'h0F0F;
    rom[0] = 16'hA5C3;
    rom[4] = 16'hBEEF;
    rom[5] = 16'hDEAD;
    rom[8] = 16'h1111;
    rom[9] = 16'h2222;
    test_reset;
    test_idle;
    test_read;
    test_write(32'd1024, 32'h12345678, 1'b0, 0, 32'hDEADBEEF);
    test_write(32'd1028, 32'hCAFEF00D, 1'b1, 1, 32'hDEADBEEF);
    test_reset_mid_write;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
